// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex sum display: scan states,
// blanking values and the active-low 7-segment glyph table.
package hex_disp_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    DIG0  = 2'd1,
    DIG1  = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [3:0] AN_DIG0   = 4'b1110;
  localparam logic [3:0] AN_DIG1   = 4'b1101;

  // Active-low gfedcba glyphs for 0..F
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to active-low 7-segment decoder driven by the
// package glyph table.
module hex_to_seg7
  import hex_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[digit];

endmodule

// File: rtl/hex_sum_display.sv
// Captures the adder result {cout, sum} on a synchronized load edge and
// scans it as two hex digits on a multiplexed active-low display.
module hex_sum_display
  import hex_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sum,
  input  logic       cout,
  input  logic       load,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       ovf_led
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic             load_ff1_r;
  logic             load_ff2_r;
  logic             load_ff3_r;
  logic             load_edge_s;
  logic [4:0]       value_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;
  scan_state_e      state_r;
  scan_state_e      next_state_s;
  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic [3:0]       dec_in_s;
  logic [6:0]       glyph_s;
  logic [3:0]       next_an_s;
  logic [6:0]       next_seg_s;

  assign load_edge_s = load_ff2_r & ~load_ff3_r;
  assign tick_s      = (cnt_r == CNT_LAST);

  // Two-flop synchronizer plus a third flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_ff1_r <= 1'b0;
      load_ff2_r <= 1'b0;
      load_ff3_r <= 1'b0;
    end else begin
      load_ff1_r <= load;
      load_ff2_r <= load_ff1_r;
      load_ff3_r <= load_ff2_r;
    end
  end

  // Captured result and overflow indicator, updated once per load edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= 5'h00;
      ovf_r   <= 1'b0;
    end else if (load_edge_s) begin
      value_r <= {cout, sum};
      ovf_r   <= cout;
    end else begin
      value_r <= value_r;
      ovf_r   <= ovf_r;
    end
  end

  // Refresh divider: one tick per digit slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Next scan state and the digit nibble it will display
  always_comb begin
    next_state_s = DIG0;
    dec_in_s     = value_r[3:0];
    case (state_r)
      BLANK:   next_state_s = DIG0;
      DIG0:    next_state_s = DIG1;
      DIG1:    next_state_s = DIG0;
      default: next_state_s = DIG0;
    endcase
    if (next_state_s == DIG1) begin
      dec_in_s = {3'b000, value_r[4]};
    end else begin
      dec_in_s = value_r[3:0];
    end
  end

  hex_to_seg7 u_dec (
    .digit (dec_in_s),
    .seg   (glyph_s)
  );

  // Anode/segment pattern for the slot being entered; blank slots still count
  always_comb begin
    next_an_s  = AN_OFF;
    next_seg_s = SEG_BLANK;
    if (next_state_s == DIG1) begin
      if (BLANK_LZ && !value_r[4]) begin
        next_an_s  = AN_OFF;
        next_seg_s = SEG_BLANK;
      end else begin
        next_an_s  = AN_DIG1;
        next_seg_s = glyph_s;
      end
    end else begin
      next_an_s  = AN_DIG0;
      next_seg_s = glyph_s;
    end
  end

  // Scan FSM with registered display outputs, advancing only on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BLANK;
      an_r    <= AN_OFF;
      seg_r   <= SEG_BLANK;
      dp_r    <= 1'b1;
    end else if (tick_s) begin
      state_r <= next_state_s;
      an_r    <= next_an_s;
      seg_r   <= next_seg_s;
      dp_r    <= 1'b1;
    end else begin
      state_r <= state_r;
      an_r    <= an_r;
      seg_r   <= seg_r;
      dp_r    <= 1'b1;
    end
  end

  assign seg     = seg_r;
  assign an      = an_r;
  assign dp      = dp_r;
  assign ovf_led = ovf_r;

endmodule
